// File: rtl/imm_pack_pkg.sv
// Shared immediate-format codes and packer FSM encodings.
// Used by the packer, its range/align checker and the decode-side extender.
// Pure declarations, no logic.
package imm_pack_pkg;

  // imm_src format codes (RV32I immediate layouts)
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Bit positions inside the 3-bit err vector {src_err, align_err, range_err}
  localparam int ERR_SRC   = 2;
  localparam int ERR_ALIGN = 1;
  localparam int ERR_RANGE = 0;

  // Packer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_PACK  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/imm_check.sv
// Range/alignment checker for an immediate against its target format.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to sample err.
module imm_check
  import imm_pack_pkg::*;
(
  input  logic [31:0] imm,
  input  logic [2:0]  imm_src,
  output logic [2:0]  err
);

  // A field fits a signed immediate when all bits above the top kept bit equal the sign.
  always_comb begin
    err = 3'b000;
    case (imm_src)
      IMM_I, IMM_S: begin
        err[ERR_RANGE] = !((&imm[31:11]) || !(|imm[31:11]));
      end
      IMM_B: begin
        err[ERR_RANGE] = !((&imm[31:12]) || !(|imm[31:12]));
        err[ERR_ALIGN] = imm[0];
      end
      IMM_J: begin
        err[ERR_RANGE] = !((&imm[31:20]) || !(|imm[31:20]));
        err[ERR_ALIGN] = imm[0];
      end
      IMM_U: begin
        err[ERR_RANGE] = |imm[11:0];
      end
      default: begin
        err[ERR_SRC] = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_pack.sv
// Packs an immediate into the immediate fields of a template instruction.
// Latency: out_valid in the third cycle after the accept cycle (IDLE, CHECK, PACK, HOLD).
// Backpressure: result held in HOLD until out_ready; in_ready only in IDLE.
module imm_pack
  import imm_pack_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] imm,
  input  logic [2:0]  imm_src,
  input  logic [31:0] base,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic [2:0]  err,
  output logic [7:0]  err_cnt
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] imm_q;
  logic [2:0]  src_q;
  logic [31:0] base_q;
  logic [2:0]  chk_err;
  logic [31:0] packed_instr;

  imm_check u_check (
    .imm     (imm_q),
    .imm_src (src_q),
    .err     (chk_err)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_HOLD);

  // State register; reset drops any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Fixed walk through CHECK and PACK, then wait in HOLD for the consumer.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (in_valid) state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = ST_PACK;
      ST_PACK:  state_nxt = ST_HOLD;
      ST_HOLD:  if (out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Capture the request only on the accept handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imm_q  <= 32'd0;
      src_q  <= 3'd0;
      base_q <= 32'd0;
    end else if (state == ST_IDLE && in_valid) begin
      imm_q  <= imm;
      src_q  <= imm_src;
      base_q <= base;
    end
  end

  // Overwrite only the immediate fields; illegal formats leave the template untouched.
  always_comb begin
    packed_instr = base_q;
    case (src_q)
      IMM_I: packed_instr[31:20] = imm_q[11:0];
      IMM_S: begin
        packed_instr[31:25] = imm_q[11:5];
        packed_instr[11:7]  = imm_q[4:0];
      end
      IMM_B: begin
        packed_instr[31]    = imm_q[12];
        packed_instr[30:25] = imm_q[10:5];
        packed_instr[11:8]  = imm_q[4:1];
        packed_instr[7]     = imm_q[11];
      end
      IMM_J: begin
        packed_instr[31]    = imm_q[20];
        packed_instr[30:21] = imm_q[10:1];
        packed_instr[20]    = imm_q[11];
        packed_instr[19:12] = imm_q[19:12];
      end
      IMM_U: packed_instr[31:12] = imm_q[31:12];
      default: packed_instr = base_q;
    endcase
  end

  // err is latched in CHECK and instr in PACK, so both are stable throughout HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err   <= 3'b000;
      instr <= 32'd0;
    end else begin
      if (state == ST_CHECK) err   <= chk_err;
      if (state == ST_PACK)  instr <= packed_instr;
    end
  end

  // Count delivered results carrying any error, saturating at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (state == ST_HOLD && out_ready && (|err) && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_imm_pack.sv
// Self-checking bench for imm_pack: vector table, backpressure, reset, saturation, random round trip.
// Expected results are queued at drive time and compared when the result handshake happens.
// Round-trip entries are checked by an independent RV32I immediate decoder.
module tb_imm_pack;
  import imm_pack_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] imm;
  logic [2:0]  imm_src;
  logic [31:0] base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [2:0]  err;
  logic [7:0]  err_cnt;

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  src;
    logic [31:0] base;
    logic [31:0] exp_instr;
    logic [2:0]  exp_err;
  } vec_t;

  typedef struct {
    logic        rt;
    logic [31:0] imm;
    logic [2:0]  src;
    logic [31:0] exp_instr;
    logic [2:0]  exp_err;
  } sb_t;

  sb_t  sb[$];
  sb_t  mon_e;
  int   checks  = 0;
  int   errors  = 0;
  int   exp_cnt = 0;

  imm_pack dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm       (imm),
    .imm_src   (imm_src),
    .base      (base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // RV32I immediate extraction, written from the ISA layouts.
  function automatic logic [31:0] decode(input logic [31:0] i, input logic [2:0] s);
    case (s)
      IMM_I:   return {{20{i[31]}}, i[31:20]};
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return {i[31:12], 12'd0};
    endcase
  endfunction

  // Scoreboard: compare each delivered result against the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got instr 0x%08h, want no result", instr);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.rt) begin
          check("rt_imm", decode(instr, mon_e.src), mon_e.imm);
          check("rt_err", 32'(err), 32'd0);
        end else begin
          check("instr", instr, mon_e.exp_instr);
          check("err", 32'(err), 32'(mon_e.exp_err));
        end
        if (mon_e.exp_err != 3'b000 && exp_cnt < 255) exp_cnt++;
      end
    end
  end

  // One transaction; hold > 0 keeps out_ready low for that many HOLD cycles.
  task automatic send(input logic [31:0] i, input logic [2:0] s, input logic [31:0] b,
                      input sb_t e, input int hold);
    int n;
    int lat;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid  = 1'b1;
    imm       = i;
    imm_src   = s;
    base      = b;
    out_ready = (hold == 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    imm      = $urandom;
    base     = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    check("latency", 32'(lat), 32'd3);
    if (!out_valid) begin
      sb.delete();
      return;
    end
    for (int k = 0; k < hold; k++) begin
      check("bp_instr", instr, e.exp_instr);
      check("bp_err", 32'(err), 32'(e.exp_err));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b1;
      imm      = 32'h0000_0ABC;
      imm_src  = IMM_I;
      base     = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
    end
    if (hold > 0) begin
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("err_cnt", 32'(err_cnt), 32'(exp_cnt));
  endtask

  vec_t        vecs[14];
  sb_t         e;
  logic [31:0] r;
  logic [31:0] ri;
  logic [2:0]  rs;

  initial begin
    vecs[0]  = '{32'hFFFF_F800, IMM_I, 32'h0000_0013, 32'h8000_0013, 3'b000};
    vecs[1]  = '{32'h0000_0FFE, IMM_B, 32'h0000_0063, 32'h7E00_0FE3, 3'b000};
    vecs[2]  = '{32'h0000_0003, IMM_B, 32'h0000_0063, 32'h0000_0163, 3'b010};
    vecs[3]  = '{32'h1234_5001, IMM_U, 32'h0000_0037, 32'h1234_5037, 3'b001};
    vecs[4]  = '{32'h1234_5678, 3'b110, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b100};
    vecs[5]  = '{32'hFFFF_FFFC, IMM_S, 32'h0000_2023, 32'hFE00_2E23, 3'b000};
    vecs[6]  = '{32'h0000_0800, IMM_J, 32'h0000_006F, 32'h0010_006F, 3'b000};
    vecs[7]  = '{32'h0010_0000, IMM_J, 32'h0000_006F, 32'h8000_006F, 3'b001};
    vecs[8]  = '{32'h0000_0800, IMM_I, 32'h0000_0013, 32'h8000_0013, 3'b001};
    vecs[9]  = '{32'hABCD_E000, IMM_U, 32'h0000_0537, 32'hABCD_E537, 3'b000};
    vecs[10] = '{32'h0000_0004, 3'b111, 32'h0123_4567, 32'h0123_4567, 3'b100};
    vecs[11] = '{32'hFFFF_F000, IMM_B, 32'h0000_0063, 32'h8000_0063, 3'b000};
    vecs[12] = '{32'h0000_0003, IMM_J, 32'h0000_006F, 32'h0020_006F, 3'b010};
    vecs[13] = '{32'h0000_0010, 3'b101, 32'hCAFE_F00D, 32'hCAFE_F00D, 3'b100};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    imm = 32'd0; imm_src = 3'd0; base = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Vector table
    foreach (vecs[v]) begin
      e = '{1'b0, vecs[v].imm, vecs[v].src, vecs[v].exp_instr, vecs[v].exp_err};
      send(vecs[v].imm, vecs[v].src, vecs[v].base, e, 0);
    end

    // Backpressure: five stalled HOLD cycles with a competing request
    e = '{1'b0, 32'h0000_07FF, IMM_I, 32'h7FF0_0093, 3'b000};
    send(32'h0000_07FF, IMM_I, 32'h0000_0093, e, 5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_no_extra_result", 32'(out_valid), 32'd0);
    end

    // Reset while in PACK
    @(negedge clk);
    in_valid = 1'b1; imm = 32'h0000_0001; imm_src = IMM_U; base = 32'h0000_0037;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("pack_out_valid", 32'(out_valid), 32'd0);
    check("pack_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_err_cnt", 32'(err_cnt), 32'd0);
    check("midrst_instr", instr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    exp_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("midrst_no_result", 32'(out_valid), 32'd0);
    end

    // err_cnt saturation
    for (int k = 0; k < 260; k++) begin
      e = '{1'b0, 32'h0000_0001, IMM_U, 32'h0000_0037, 3'b001};
      send(32'h0000_0001, IMM_U, 32'h0000_0037, e, 0);
    end
    check("err_cnt_saturated", 32'(err_cnt), 32'd255);

    // Random legal round trip
    for (int k = 0; k < 10000; k++) begin
      r  = $urandom;
      rs = 3'($urandom_range(0, 4));
      case (rs)
        IMM_I, IMM_S: ri = {{20{r[11]}}, r[11:0]};
        IMM_B:        ri = {{19{r[12]}}, r[12:1], 1'b0};
        IMM_J:        ri = {{11{r[20]}}, r[20:1], 1'b0};
        default:      ri = {r[31:12], 12'd0};
      endcase
      e = '{1'b1, ri, rs, 32'd0, 3'b000};
      send(ri, rs, $urandom, e, 0);
    end
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
